// File: rtl/alu_result_buffer.sv
// ---------------------------------------------------------------------------
// alu_result_buffer
//
// Registered output stage that sits directly behind the 32-bit add/subtract
// circuit. Each accepted result is stored together with its signed-overflow
// bit and a destination tag in a 2-entry FIFO. Entries leave in order towards
// the writeback consumer. A sticky overflow flag and a saturating overflow
// event counter are kept for the status/exception logic.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   in_valid     in   upstream result valid
//   in_ready     out  buffer can accept an entry this cycle
//   in_result    in   adder result            [WIDTH-1:0]
//   in_overflow  in   adder signed-overflow bit
//   in_tag       in   destination tag         [TAG_W-1:0]
//   out_valid    out  head entry valid
//   out_ready    in   consumer accepts head entry
//   out_result   out  head entry result       [WIDTH-1:0]
//   out_overflow out  head entry overflow bit
//   out_tag      out  head entry tag          [TAG_W-1:0]
//   out_zero     out  head result equals zero (independent of out_valid)
//   ovf_sticky   out  set by any accepted overflowing entry
//   ovf_count    out  saturating count of accepted overflowing entries
//   clear_ovf    in   synchronous clear of ovf_sticky / ovf_count
// ---------------------------------------------------------------------------
module alu_result_buffer #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_overflow,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_overflow,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clear_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Two storage slots, addressed by single-bit read/write pointers.
    logic [WIDTH-1:0] result_mem   [2];
    logic             overflow_mem [2];
    logic [TAG_W-1:0] tag_mem      [2];

    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] occupancy;

    logic push;
    logic pop;

    // Handshake flags come only from registered occupancy, so in_ready has
    // no combinational dependence on out_ready.
    assign in_ready  = (occupancy != 2'd2);
    assign out_valid = (occupancy != 2'd0);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Head entry is always presented, even when empty; the slot contents
    // simply hold their last value.
    assign out_result   = result_mem[rd_ptr];
    assign out_overflow = overflow_mem[rd_ptr];
    assign out_tag      = tag_mem[rd_ptr];
    assign out_zero     = (out_result == '0);

    // Storage write: an accepted entry lands in the slot at the write pointer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_mem[0]   <= '0;
            result_mem[1]   <= '0;
            overflow_mem[0] <= 1'b0;
            overflow_mem[1] <= 1'b0;
            tag_mem[0]      <= '0;
            tag_mem[1]      <= '0;
        end else if (push) begin
            result_mem[wr_ptr]   <= in_result;
            overflow_mem[wr_ptr] <= in_overflow;
            tag_mem[wr_ptr]      <= in_tag;
        end
    end

    // Pointer and occupancy bookkeeping. A simultaneous push and pop leaves
    // occupancy unchanged while both pointers advance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Overflow status. An overflowing push takes priority over clear_ovf:
    // when both happen together the history restarts at one event.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else if (push && in_overflow) begin
            ovf_sticky <= 1'b1;
            if (clear_ovf) begin
                ovf_count <= CNT_ONE;
            end else if (ovf_count != CNT_MAX) begin
                ovf_count <= ovf_count + CNT_ONE;
            end
        end else if (clear_ovf) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end
    end

endmodule
